// File: rtl/systolic_skew_feeder.sv
// rtl/systolic_skew_feeder.sv - skewed A/B operand feeder with job-framed enable for a systolic array
// Lane r of A / lane c of B is delayed r+1 / c+1 cycles; en_out is the OR of the tags at every tap.
module systolic_skew_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int ROWS       = 8,
    parameter int COLS       = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_last,
    input  logic [ROWS*DATA_WIDTH-1:0] in_a,
    input  logic [COLS*DATA_WIDTH-1:0] in_b,
    output logic [ROWS*DATA_WIDTH-1:0] a_out,
    output logic [COLS*DATA_WIDTH-1:0] b_out,
    output logic                       en_out,
    output logic                       busy,
    output logic [15:0]                bubble_cnt
);

    localparam int M  = (ROWS > COLS) ? ROWS : COLS;
    localparam int CW = (M > 1) ? $clog2(M) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FEED  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [CW-1:0]              r_drain_cnt;
    logic [CW-1:0]              w_drain_cnt_nxt;
    logic [15:0]                r_bubble_cnt;
    logic [15:0]                w_bubble_cnt_nxt;
    logic                       w_push_tag;
    logic                       w_push_data;
    logic [ROWS*DATA_WIDTH-1:0] w_push_a;
    logic [COLS*DATA_WIDTH-1:0] w_push_b;
    logic [M-1:0]               r_tag;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_drain_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_drain_cnt  <= w_drain_cnt_nxt;
            r_bubble_cnt <= w_bubble_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_drain_cnt_nxt  = r_drain_cnt;
        w_bubble_cnt_nxt = r_bubble_cnt;
        in_ready         = 1'b0;
        w_push_tag       = 1'b0;
        w_push_data      = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_push_tag       = 1'b1;
                    w_push_data      = 1'b1;
                    w_bubble_cnt_nxt = '0;
                    if (in_last) begin
                        w_state_nxt     = S_DRAIN;
                        w_drain_cnt_nxt = CW'(M - 1);
                    end else begin
                        w_state_nxt = S_FEED;
                    end
                end
            end
            S_FEED: begin
                // A missing beat still pushes a tagged zero entry so en_out never gaps.
                in_ready   = 1'b1;
                w_push_tag = 1'b1;
                if (in_valid) begin
                    w_push_data = 1'b1;
                    if (in_last) begin
                        w_state_nxt     = S_DRAIN;
                        w_drain_cnt_nxt = CW'(M - 1);
                    end
                end else if (r_bubble_cnt != 16'hFFFF) begin
                    w_bubble_cnt_nxt = r_bubble_cnt + 16'd1;
                end
            end
            S_DRAIN: begin
                if (r_drain_cnt == '0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_drain_cnt_nxt = r_drain_cnt - CW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_push_a = w_push_data ? in_a : '0;
    assign w_push_b = w_push_data ? in_b : '0;

    // Tags are identical across lanes at equal depth, so one chain of depth M serves every tap.
    generate
        if (M == 1) begin : g_tag_single
            always_ff @(posedge clk) begin
                if (rst) r_tag <= '0;
                else     r_tag <= w_push_tag;
            end
        end else begin : g_tag_chain
            always_ff @(posedge clk) begin
                if (rst) r_tag <= '0;
                else     r_tag <= {r_tag[M-2:0], w_push_tag};
            end
        end
    endgenerate

    genvar gr;
    generate
        for (gr = 0; gr < ROWS; gr++) begin : g_a_lane
            logic [(gr+1)*DATA_WIDTH-1:0] r_pipe;
            if (gr == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (rst) r_pipe <= '0;
                    else     r_pipe <= w_push_a[DATA_WIDTH-1:0];
                end
            end else begin : g_deep
                always_ff @(posedge clk) begin
                    if (rst) r_pipe <= '0;
                    else     r_pipe <= {r_pipe[gr*DATA_WIDTH-1:0], w_push_a[gr*DATA_WIDTH +: DATA_WIDTH]};
                end
            end
            assign a_out[gr*DATA_WIDTH +: DATA_WIDTH] = r_pipe[(gr+1)*DATA_WIDTH-1 -: DATA_WIDTH];
        end
    endgenerate

    genvar gc;
    generate
        for (gc = 0; gc < COLS; gc++) begin : g_b_lane
            logic [(gc+1)*DATA_WIDTH-1:0] r_pipe;
            if (gc == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (rst) r_pipe <= '0;
                    else     r_pipe <= w_push_b[DATA_WIDTH-1:0];
                end
            end else begin : g_deep
                always_ff @(posedge clk) begin
                    if (rst) r_pipe <= '0;
                    else     r_pipe <= {r_pipe[gc*DATA_WIDTH-1:0], w_push_b[gc*DATA_WIDTH +: DATA_WIDTH]};
                end
            end
            assign b_out[gc*DATA_WIDTH +: DATA_WIDTH] = r_pipe[(gc+1)*DATA_WIDTH-1 -: DATA_WIDTH];
        end
    endgenerate

    assign en_out     = |r_tag;
    assign busy       = (r_state != S_IDLE) || en_out;
    assign bubble_cnt = r_bubble_cnt;

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// tb/tb_systolic_skew_feeder.sv - directed checks of skew, framing, bubbles and reset for the feeder
// Each step row drives one edge and lists the hand-computed values seen in the following cycle.
module tb_systolic_skew_feeder;

    localparam int DW = 8;
    localparam int R  = 4;
    localparam int C  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic          in_last;
    logic [R*DW-1:0] in_a;
    logic [C*DW-1:0] in_b;
    logic [R*DW-1:0] a_out;
    logic [C*DW-1:0] b_out;
    logic          en_out;
    logic          busy;
    logic [15:0]   bubble_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    systolic_skew_feeder #(.DATA_WIDTH(DW), .ROWS(R), .COLS(C)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_last    (in_last),
        .in_a       (in_a),
        .in_b       (in_b),
        .a_out      (a_out),
        .b_out      (b_out),
        .en_out     (en_out),
        .busy       (busy),
        .bubble_cnt (bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic signed [31:0] lane(input logic [31:0] bus, input int idx);
        logic [7:0] x;
        x = bus[idx*DW +: DW];
        return {{24{x[7]}}, x};
    endfunction

    task automatic set_beat(input int k);
        for (int r = 0; r < R; r++) in_a[r*DW +: DW] = 8'((r + 1) * k);
        for (int c = 0; c < C; c++) in_b[c*DW +: DW] = 8'((c + 5) * k);
    endtask

    task automatic step(input string tag, input int cyc, input bit v, input int k, input bit l,
                        input int e_rdy, input int e_en, input int e_busy,
                        input int e_a0, input int e_a3, input int e_b3, input int e_bub);
        string t;
        in_valid = v;
        in_last  = l;
        set_beat(k);
        @(posedge clk);
        #1;
        t = $sformatf("%s c%0d", tag, cyc);
        check({t, " in_ready"}, in_ready, e_rdy);
        check({t, " en_out"}, en_out, e_en);
        check({t, " busy"}, busy, e_busy);
        check({t, " a lane0"}, lane(a_out, 0), e_a0);
        check({t, " a lane3"}, lane(a_out, 3), e_a3);
        check({t, " b lane3"}, lane(b_out, 3), e_b3);
        check({t, " bubble_cnt"}, bubble_cnt, e_bub);
    endtask

    // Three-beat job; in_valid held high through DRAIN must be ignored.
    task automatic basic_job(input string tag);
        //           c  v  k  l   rdy en busy a0  a3  b3 bub
        step(tag,  1, 1, 1, 0,   1, 1, 1,   1,  0,  0, 0);
        step(tag,  2, 1, 2, 0,   1, 1, 1,   2,  0,  0, 0);
        step(tag,  3, 1, 3, 1,   0, 1, 1,   3,  0,  0, 0);
        step(tag,  4, 1, 9, 0,   0, 1, 1,   0,  4,  8, 0);
        step(tag,  5, 1, 9, 0,   0, 1, 1,   0,  8, 16, 0);
        step(tag,  6, 1, 9, 0,   0, 1, 1,   0, 12, 24, 0);
        step(tag,  7, 1, 9, 0,   1, 0, 0,   0,  0,  0, 0);
        step(tag,  8, 0, 9, 0,   1, 0, 0,   0,  0,  0, 0);
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b1;
        in_last  = 1'b0;
        in_a     = '0;
        in_b     = '0;

        for (int i = 0; i < 3; i++) begin
            in_a    = $urandom;
            in_b    = $urandom;
            in_last = 1'($urandom);
            @(posedge clk);
            #1;
            check($sformatf("reset%0d a_out", i), a_out, 0);
            check($sformatf("reset%0d b_out", i), b_out, 0);
            check($sformatf("reset%0d en_out", i), en_out, 0);
            check($sformatf("reset%0d busy", i), busy, 0);
            check($sformatf("reset%0d in_ready", i), in_ready, 1);
            check($sformatf("reset%0d bubble_cnt", i), bubble_cnt, 0);
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        #1;
        check("post-reset in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        basic_job("basic");

        //               c  v  k  l   rdy en busy a0  a3  b3 bub
        step("bubble",  1, 1, 1, 0,   1, 1, 1,   1,  0,  0, 0);
        step("bubble",  2, 1, 2, 0,   1, 1, 1,   2,  0,  0, 0);
        step("bubble",  3, 0, 9, 0,   1, 1, 1,   0,  0,  0, 1);
        step("bubble",  4, 0, 9, 0,   1, 1, 1,   0,  4,  8, 2);
        step("bubble",  5, 1, 3, 1,   0, 1, 1,   3,  8, 16, 2);
        step("bubble",  6, 0, 9, 0,   0, 1, 1,   0,  0,  0, 2);
        step("bubble",  7, 0, 9, 0,   0, 1, 1,   0,  0,  0, 2);
        step("bubble",  8, 0, 9, 0,   0, 1, 1,   0, 12, 24, 2);
        step("bubble",  9, 0, 9, 0,   1, 0, 0,   0,  0,  0, 2);
        step("bubble", 10, 0, 9, 0,   1, 0, 0,   0,  0,  0, 2);

        step("b2b",  1, 1, 1, 0,   1, 1, 1,   1,  0,  0, 0);
        step("b2b",  2, 1, 2, 1,   0, 1, 1,   2,  0,  0, 0);
        step("b2b",  3, 1, 9, 0,   0, 1, 1,   0,  0,  0, 0);
        step("b2b",  4, 1, 9, 0,   0, 1, 1,   0,  4,  8, 0);
        step("b2b",  5, 1, 9, 0,   0, 1, 1,   0,  8, 16, 0);
        step("b2b",  6, 1, 9, 0,   1, 0, 0,   0,  0,  0, 0);
        step("b2b",  7, 1, 3, 0,   1, 1, 1,   3,  0,  0, 0);
        step("b2b",  8, 1, 4, 1,   0, 1, 1,   4,  0,  0, 0);
        step("b2b",  9, 1, 9, 0,   0, 1, 1,   0,  0,  0, 0);
        step("b2b", 10, 1, 9, 0,   0, 1, 1,   0, 12, 24, 0);
        step("b2b", 11, 1, 9, 0,   0, 1, 1,   0, 16, 32, 0);
        step("b2b", 12, 1, 9, 0,   1, 0, 0,   0,  0,  0, 0);

        step("single", 1, 1, -3, 1,   0, 1, 1,  -3,   0,   0, 0);
        step("single", 2, 0,  9, 0,   0, 1, 1,   0,   0,   0, 0);
        step("single", 3, 0,  9, 0,   0, 1, 1,   0,   0,   0, 0);
        step("single", 4, 0,  9, 0,   0, 1, 1,   0, -12, -24, 0);
        step("single", 5, 0,  9, 0,   1, 0, 0,   0,   0,   0, 0);
        step("single", 6, 0,  9, 0,   1, 0, 0,   0,   0,   0, 0);

        step("rstdrain", 1, 1, 1, 0,   1, 1, 1,   1,  0,  0, 0);
        step("rstdrain", 2, 1, 2, 1,   0, 1, 1,   2,  0,  0, 0);
        step("rstdrain", 3, 0, 9, 0,   0, 1, 1,   0,  0,  0, 0);
        rst      = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("rstdrain en_out", en_out, 0);
        check("rstdrain a_out", a_out, 0);
        check("rstdrain b_out", b_out, 0);
        check("rstdrain busy", busy, 0);
        check("rstdrain in_ready", in_ready, 1);
        rst = 1'b0;

        basic_job("rerun");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/systolic_skew_feeder.md
# systolic_skew_feeder

Upstream operand feeder for the `PE_Array` systolic multiplier. It accepts one A column (ROWS elements) and one B row (COLS elements) per beat over a valid/ready handshake. It skews them so that row i of A and column j of B arrive i and j cycles late, and drives the array's `A`, `B` and `en` inputs. It frames each job so that `en` stays continuously high for the whole job, then falls exactly once, which is the falling edge the array uses to time its `valid`.

## Interface
- `DATA_WIDTH`, 8: signed element width.
- `ROWS`, 8: array rows (A lanes); must be ≥1.
- `COLS`, 8: array columns (B lanes); must be ≥1.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `in_valid`  in  1  beat offered.
- `in_ready`  out  1  feeder can accept a beat this cycle.
- `in_last`  in  1  offered beat is the final k-index of the job.
- `in_a`  in  ROWS*DATA_WIDTH  A column k; lane r at bits [(r+1)*DW-1 : r*DW].
- `in_b`  in  COLS*DATA_WIDTH  B row k; lane c at same packing.
- `a_out`  out  ROWS*DATA_WIDTH  to array `A`.
- `b_out`  out  COLS*DATA_WIDTH  to array `B`.
- `en_out`  out  1  to array `en`.
- `busy`  out  1  state ≠ IDLE or `en_out` high.
- `bubble_cnt`  out  16  zero beats inserted in the current/last job; saturates at 0xFFFF.

## Operation
- Let M = max(ROWS, COLS). Lane r of A passes through r+1 registers; lane c of B passes through c+1 registers. Every stage shifts every cycle, with no stall path.
- Each stage entry carries a tag bit. `en_out` = OR of the tags at all A/B output taps.
- FSM states:
  - IDLE: `in_ready`=1. On accept, go to FEED, or to DRAIN if `in_last`=1. `bubble_cnt` clears to 0 on that first accept.
  - FEED: `in_ready`=1. Every cycle, one entry is pushed with tag=1:
    - if a beat is accepted, the entry is the beat's data;
    - if `in_valid`=0, the entry is an all-zero beat and `bubble_cnt`++ (saturating).
    - Accepting a beat with `in_last`=1 moves the FSM to DRAIN.
  - DRAIN: `in_ready`=0. Zero data with tag=0 is pushed. The FSM stays in DRAIN for exactly M cycles, then returns to IDLE.
- In IDLE with no accept, zero data with tag=0 is pushed.
- Zero bubbles are algebraically neutral: they shift all lanes uniformly, so products still meet at PE(i,j) correctly.
- No arithmetic is performed. Data passes bit-exact, and signedness is preserved.

## Timing
- Reset (`rst`=1 at an edge):
  - all delay registers and tags clear to 0;
  - FSM enters IDLE;
  - outputs become `a_out`=0, `b_out`=0, `en_out`=0, `busy`=0, `in_ready`=1, `bubble_cnt`=0.
  - Reset mid-job abandons the job silently, and `en_out` drops the next cycle.
- A beat accepted at edge t appears on A lane r at cycle t+1+r and on B lane c at cycle t+1+c.
- `en_out` rises at cycle t0+1, where t0 is the first accept. It stays high through cycle L+M, where L is the accept edge of the `in_last` beat, and is low at L+M+1.
- No gaps in `en_out` within a job, including bubbles.
- IDLE is re-entered at cycle L+M+1, and `in_ready`=1 there. A new beat accepted then gives `en_out`=1 at L+M+2. This guarantees at least one low cycle between jobs, so the array sees exactly one falling edge per job.
- Single-beat job (first beat has `in_last`): the FSM goes IDLE→DRAIN directly, and `en_out` is high for cycles t0+1 … t0+M.
- Both `in_valid`=0 and `in_ready`=0 in DRAIN: nothing is accepted, and the input is ignored.
- Degenerate ROWS=COLS=1 (M=1): DRAIN lasts 1 cycle.

## Test plan
1. **Reset values.** With ROWS=COLS=4, hold `rst` 3 cycles while `in_valid`=1 with random data. Required: all outputs stay at their reset values, and `in_ready`=1 after release.
2. **Basic 3-beat job.** Send beats at cycles 0, 1, 2 with A lanes = {1,2,3,4}·k and B = {5,6,7,8}·k, and `in_last` on k=3. Required:
   - A lane 3 shows 4, 8, 12 at cycles 4, 5, 6;
   - `en_out` is high for cycles 1–6;
   - `in_ready`=0 for cycles 3–6;
   - IDLE at cycle 7.
3. **Bubbles.** Same job, but `in_valid`=0 for 2 cycles between beats 1 and 2. Required:
   - zeros appear on the lanes between the beats;
   - `en_out` stays continuously high for cycles 1–8;
   - `bubble_cnt`=2.
4. **End-to-end.** Feed a ROWS=COLS=4 signed job (values −128…127, K=4) into a `PE_Array` instance. Required: exactly one `en` falling edge, and C matches the reference A×B once the array's `valid` asserts.
5. **Back-to-back jobs.** Hold `in_valid`=1 continuously across two 2-beat jobs. Required:
   - second job accepted at cycle L+M+1;
   - `en_out` low for exactly one cycle between the jobs;
   - `bubble_cnt` restarts at 0.
6. **Reset mid-DRAIN.** Assert `rst` at the second DRAIN cycle. Required: `en_out`=0 and all lanes 0 the next cycle, and a fresh job then runs per scenario 2.
